// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: merges two request ports onto a split write/read memory interface,
// with round-robin or fixed priority and an exclusive lock mode for port 1.
module dmem_arbiter #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter bit          RR_EN         = 1'b1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_p0_valid,
   output logic                      o_p0_ready,
   input  logic                      i_p0_we,
   input  logic [DATA_WIDTH/8-1:0]   i_p0_be,
   input  logic [ADDRESS_WIDTH-1:0]  i_p0_addr,
   input  logic [DATA_WIDTH-1:0]     i_p0_wdata,
   output logic                      o_p0_rvalid,
   output logic [DATA_WIDTH-1:0]     o_p0_rdata,
   input  logic                      i_p1_valid,
   output logic                      o_p1_ready,
   input  logic                      i_p1_we,
   input  logic [DATA_WIDTH/8-1:0]   i_p1_be,
   input  logic [ADDRESS_WIDTH-1:0]  i_p1_addr,
   input  logic [DATA_WIDTH-1:0]     i_p1_wdata,
   output logic                      o_p1_rvalid,
   output logic [DATA_WIDTH-1:0]     o_p1_rdata,
   input  logic                      i_p1_lock,
   output logic                      o_locked,
   output logic                      o_mea,
   output logic [DATA_WIDTH/8-1:0]   o_wea,
   output logic [ADDRESS_WIDTH-1:0]  o_adra,
   output logic [DATA_WIDTH-1:0]     o_da,
   output logic                      o_meb,
   output logic [ADDRESS_WIDTH-1:0]  o_adrb,
   input  logic [DATA_WIDTH-1:0]     i_qb
);

   localparam int unsigned BE_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {ARB, DRAIN, LOCKED} state_t;

   state_t                  state_q;
   logic                    prio_q;
   logic [1:0]              rv_q;
   logic [DATA_WIDTH-1:0]   hold0_q;
   logic [DATA_WIDTH-1:0]   hold1_q;

   logic                    grant0;
   logic                    grant1;
   logic                    acc;
   logic                    rd_acc;
   logic                    sel_we;
   logic [BE_W-1:0]         sel_be;
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;

   // Grant decision: prio_q names the port that wins a tie in round-robin mode.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!i_rst) begin
         case (state_q)
            ARB: begin
               if (i_p0_valid && i_p1_valid) begin
                  if (RR_EN && prio_q) grant1 = 1'b1;
                  else                 grant0 = 1'b1;
               end else begin
                  grant0 = i_p0_valid;
                  grant1 = i_p1_valid;
               end
            end
            LOCKED:  grant1 = i_p1_valid;
            default: ;
         endcase
      end
   end

   assign o_p0_ready = grant0;
   assign o_p1_ready = grant1;
   assign acc        = grant0 | grant1;

   assign sel_we    = grant1 ? i_p1_we    : i_p0_we;
   assign sel_be    = grant1 ? i_p1_be    : i_p0_be;
   assign sel_addr  = grant1 ? i_p1_addr  : i_p0_addr;
   assign sel_wdata = grant1 ? i_p1_wdata : i_p0_wdata;
   assign rd_acc    = acc & ~sel_we;

   // Memory ports are driven in the accept cycle itself.
   assign o_mea  = acc & sel_we;
   assign o_wea  = (acc && sel_we) ? sel_be : BE_W'(0);
   assign o_adra = sel_addr;
   assign o_da   = sel_wdata;
   assign o_meb  = rd_acc;
   assign o_adrb = sel_addr;

   // Read data arrives from memory one cycle after accept; the hold registers keep the last value.
   assign o_p0_rvalid = rv_q[0] & ~i_rst;
   assign o_p1_rvalid = rv_q[1] & ~i_rst;
   assign o_p0_rdata  = i_rst ? DATA_WIDTH'(0) : (rv_q[0] ? i_qb : hold0_q);
   assign o_p1_rdata  = i_rst ? DATA_WIDTH'(0) : (rv_q[1] ? i_qb : hold1_q);
   assign o_locked    = (state_q == LOCKED) & i_p1_lock & ~i_rst;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ARB;
         prio_q  <= 1'b0;
         rv_q    <= 2'b00;
         hold0_q <= DATA_WIDTH'(0);
         hold1_q <= DATA_WIDTH'(0);
      end else begin
         if (acc) prio_q <= grant0;
         rv_q <= {grant1 & ~i_p1_we, grant0 & ~i_p0_we};
         if (rv_q[0]) hold0_q <= i_qb;
         if (rv_q[1]) hold1_q <= i_qb;
         // DRAIN never grants, so the only response in flight is the one completing now.
         case (state_q)
            ARB:     if (i_p1_lock) state_q <= DRAIN;
            DRAIN: begin
               if (!i_p1_lock)   state_q <= ARB;
               else if (!rd_acc) state_q <= LOCKED;
            end
            LOCKED:  if (!i_p1_lock) state_q <= ARB;
            default: state_q <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a round-robin instance with a byte-enabled memory model
// and a fixed-priority instance with an address-echo memory.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        r_v0, r_rdy0, r_we0, r_rv0;
   logic [3:0]  r_be0;
   logic [31:0] r_a0, r_d0, r_q0;
   logic        r_v1, r_rdy1, r_we1, r_rv1;
   logic [3:0]  r_be1;
   logic [31:0] r_a1, r_d1, r_q1;
   logic        r_lock, r_locked, r_mea, r_meb;
   logic [3:0]  r_wea;
   logic [31:0] r_adra, r_da, r_adrb, r_qb;

   logic        f_v0, f_rdy0, f_we0, f_rv0;
   logic [3:0]  f_be0;
   logic [31:0] f_a0, f_d0, f_q0;
   logic        f_v1, f_rdy1, f_we1, f_rv1;
   logic [3:0]  f_be1;
   logic [31:0] f_a1, f_d1, f_q1;
   logic        f_lock, f_locked, f_mea, f_meb;
   logic [3:0]  f_wea;
   logic [31:0] f_adra, f_da, f_adrb, f_qb;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] rq0[$];
   logic [31:0] rq1[$];
   logic [31:0] fq0[$];
   logic [31:0] fq1[$];
   logic [31:0] mem [64];

   dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RR_EN(1'b1)) u_rr (
      .i_clk(clk), .i_rst(rst),
      .i_p0_valid(r_v0), .o_p0_ready(r_rdy0), .i_p0_we(r_we0), .i_p0_be(r_be0),
      .i_p0_addr(r_a0), .i_p0_wdata(r_d0), .o_p0_rvalid(r_rv0), .o_p0_rdata(r_q0),
      .i_p1_valid(r_v1), .o_p1_ready(r_rdy1), .i_p1_we(r_we1), .i_p1_be(r_be1),
      .i_p1_addr(r_a1), .i_p1_wdata(r_d1), .o_p1_rvalid(r_rv1), .o_p1_rdata(r_q1),
      .i_p1_lock(r_lock), .o_locked(r_locked),
      .o_mea(r_mea), .o_wea(r_wea), .o_adra(r_adra), .o_da(r_da),
      .o_meb(r_meb), .o_adrb(r_adrb), .i_qb(r_qb)
   );

   dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RR_EN(1'b0)) u_fp (
      .i_clk(clk), .i_rst(rst),
      .i_p0_valid(f_v0), .o_p0_ready(f_rdy0), .i_p0_we(f_we0), .i_p0_be(f_be0),
      .i_p0_addr(f_a0), .i_p0_wdata(f_d0), .o_p0_rvalid(f_rv0), .o_p0_rdata(f_q0),
      .i_p1_valid(f_v1), .o_p1_ready(f_rdy1), .i_p1_we(f_we1), .i_p1_be(f_be1),
      .i_p1_addr(f_a1), .i_p1_wdata(f_d1), .o_p1_rvalid(f_rv1), .o_p1_rdata(f_q1),
      .i_p1_lock(f_lock), .o_locked(f_locked),
      .o_mea(f_mea), .o_wea(f_wea), .o_adra(f_adra), .o_da(f_da),
      .o_meb(f_meb), .o_adrb(f_adrb), .i_qb(f_qb)
   );

   // Word memory indexed by addr[7:2]; reloaded with a known pattern whenever reset is high.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      end else if (r_mea) begin
         for (int b = 0; b < 4; b++)
            if (r_wea[b]) mem[r_adra[7:2]][8*b +: 8] <= r_da[8*b +: 8];
      end
      if (r_meb) r_qb <= mem[r_adrb[7:2]];
      if (f_meb) f_qb <= {16'hF00D, f_adrb[15:0]};
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: got rvalid=1 expected no response pending", nm);
   endtask

   // Monitor: every rvalid pops the scoreboard queue of its own port.
   always @(negedge clk) begin
      if (r_rv0) begin
         if (rq0.size() == 0) unexpected("r_p0_rvalid");
         else chk("r_p0_rdata", r_q0, rq0.pop_front());
      end
      if (r_rv1) begin
         if (rq1.size() == 0) unexpected("r_p1_rvalid");
         else chk("r_p1_rdata", r_q1, rq1.pop_front());
      end
      if (f_rv0) begin
         if (fq0.size() == 0) unexpected("f_p0_rvalid");
         else chk("f_p0_rdata", f_q0, fq0.pop_front());
      end
      if (f_rv1) begin
         if (fq1.size() == 0) unexpected("f_p1_rvalid");
         else chk("f_p1_rdata", f_q1, fq1.pop_front());
      end
   end

   task automatic set_r0(input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
      r_v0 = v; r_we0 = we; r_be0 = be; r_a0 = a; r_d0 = d;
   endtask

   task automatic set_r1(input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
      r_v1 = v; r_we1 = we; r_be1 = be; r_a1 = a; r_d1 = d;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      r_lock = 1'b0;
      set_r0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_r1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      f_lock = 1'b0;
      f_v0 = 1'b0; f_we0 = 1'b0; f_be0 = 4'h0; f_a0 = 32'h0; f_d0 = 32'h0;
      f_v1 = 1'b0; f_we1 = 1'b0; f_be1 = 4'h0; f_a1 = 32'h0; f_d1 = 32'h0;

      // Outputs stay quiet while reset is asserted, even with requests pending
      @(negedge clk);
      set_r0(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
      set_r1(1'b1, 1'b0, 4'hF, 32'h44, 32'h0);
      f_v0 = 1'b1;
      @(negedge clk);
      chk("rst_p0_ready", r_rdy0, 1'b0);
      chk("rst_p1_ready", r_rdy1, 1'b0);
      chk("rst_p0_rvalid", r_rv0, 1'b0);
      chk("rst_meb", r_meb, 1'b0);
      chk("rst_mea", r_mea, 1'b0);
      chk("rst_locked", r_locked, 1'b0);
      chk("rst_p0_rdata", r_q0, 32'h0);
      chk("rst_fp_p0_ready", f_rdy0, 1'b0);
      chk("rst_fp_locked", f_locked, 1'b0);
      adv();
      rst = 1'b0;
      f_v0 = 1'b0;

      // Port 0 full write then read back
      set_r0(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
      set_r1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("wr_p0_ready", r_rdy0, 1'b1);
      chk("wr_mea", r_mea, 1'b1);
      chk("wr_wea", r_wea, 4'hF);
      chk("wr_adra", r_adra, 32'h10);
      chk("wr_da", r_da, 32'hDEAD_BEEF);
      chk("wr_meb", r_meb, 1'b0);
      adv();
      set_r0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      @(negedge clk);
      chk("rd_p0_ready", r_rdy0, 1'b1);
      chk("rd_meb", r_meb, 1'b1);
      chk("rd_adrb", r_adrb, 32'h10);
      chk("rd_mea", r_mea, 1'b0);
      chk("rd_wea", r_wea, 4'h0);
      rq0.push_back(32'hDEAD_BEEF);
      adv();

      // Port 1 partial write (low two bytes) while port 0 read data returns
      set_r0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_r1(1'b1, 1'b1, 4'h3, 32'h20, 32'h1122_3344);
      @(negedge clk);
      chk("pw_p1_ready", r_rdy1, 1'b1);
      chk("pw_wea", r_wea, 4'h3);
      chk("pw_p1_rvalid", r_rv1, 1'b0);
      adv();
      set_r1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      @(negedge clk);
      chk("hold_p0_rvalid", r_rv0, 1'b0);
      chk("hold_p0_rdata", r_q0, 32'hDEAD_BEEF);
      chk("pr_p1_ready", r_rdy1, 1'b1);
      rq1.push_back(32'hA000_3344);
      adv();
      set_r1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      adv();

      // Both ports reading continuously: grants alternate starting at port 0
      for (int k = 0; k < 6; k++) begin
         set_r0(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
         set_r1(1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
         @(negedge clk);
         chk("rr_p0_ready", r_rdy0, 1'((k % 2) == 0));
         chk("rr_p1_ready", r_rdy1, 1'((k % 2) == 1));
         if (k > 0) begin
            chk("rr_p0_rvalid", r_rv0, 1'((k % 2) == 1));
            chk("rr_p1_rvalid", r_rv1, 1'((k % 2) == 0));
         end
         if ((k % 2) == 0) rq0.push_back(32'hA000_0010);
         else              rq1.push_back(32'hA000_0011);
         adv();
      end
      set_r0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_r1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      adv();

      // Unaligned byte address reaches the read port untouched
      set_r1(1'b1, 1'b0, 4'h0, 32'h13, 32'h0);
      @(negedge clk);
      chk("ua_p1_ready", r_rdy1, 1'b1);
      chk("ua_adrb", r_adrb, 32'h13);
      rq1.push_back(32'hDEAD_BEEF);
      adv();
      set_r1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      adv();

      // Lock requested in the same cycle as a port 0 read accept
      set_r0(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
      r_lock = 1'b1;
      @(negedge clk);
      chk("lk_arb_p0_ready", r_rdy0, 1'b1);
      chk("lk_arb_locked", r_locked, 1'b0);
      rq0.push_back(32'hA000_0010);
      adv();
      set_r1(1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
      @(negedge clk);
      chk("lk_drain_p0_ready", r_rdy0, 1'b0);
      chk("lk_drain_p1_ready", r_rdy1, 1'b0);
      chk("lk_drain_locked", r_locked, 1'b0);
      chk("lk_drain_p0_rvalid", r_rv0, 1'b1);
      adv();
      @(negedge clk);
      chk("lk_p0_ready", r_rdy0, 1'b0);
      chk("lk_p1_ready", r_rdy1, 1'b1);
      chk("lk_locked", r_locked, 1'b1);
      rq1.push_back(32'hA000_0011);
      adv();
      set_r1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("lk_hold_p0_ready", r_rdy0, 1'b0);
      chk("lk_hold_locked", r_locked, 1'b1);
      adv();
      r_lock = 1'b0;
      @(negedge clk);
      chk("unlk_locked", r_locked, 1'b0);
      chk("unlk_p0_ready", r_rdy0, 1'b0);
      adv();
      @(negedge clk);
      chk("unlk_arb_p0_ready", r_rdy0, 1'b1);
      rq0.push_back(32'hA000_0010);
      adv();

      // Read accepted, then reset: the response is discarded and the pointer returns to port 0
      @(negedge clk);
      chk("pre_rst_p0_ready", r_rdy0, 1'b1);
      adv();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_drop_p0_rvalid", r_rv0, 1'b0);
      chk("rst_drop_p1_rvalid", r_rv1, 1'b0);
      chk("rst_drop_p0_ready", r_rdy0, 1'b0);
      adv();
      rst = 1'b0;
      set_r1(1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
      @(negedge clk);
      chk("post_rst_p0_rvalid", r_rv0, 1'b0);
      chk("post_rst_p0_ready", r_rdy0, 1'b1);
      chk("post_rst_p1_ready", r_rdy1, 1'b0);
      rq0.push_back(32'hA000_0010);
      adv();
      @(negedge clk);
      chk("post_rst2_p0_ready", r_rdy0, 1'b0);
      chk("post_rst2_p1_ready", r_rdy1, 1'b1);
      rq1.push_back(32'hA000_0011);
      adv();
      set_r0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_r1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      adv();

      // Fixed priority: port 0 wins every cycle while both are valid
      f_v0 = 1'b1; f_a0 = 32'h100;
      f_v1 = 1'b1; f_a1 = 32'h200;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("fp_p0_ready", f_rdy0, 1'b1);
         chk("fp_p1_ready", f_rdy1, 1'b0);
         chk("fp_adrb", f_adrb, 32'h100);
         fq0.push_back(32'hF00D_0100);
         adv();
      end
      f_v0 = 1'b0;
      f_v1 = 1'b0;
      @(negedge clk);
      chk("fp_idle_meb", f_meb, 1'b0);
      chk("fp_idle_wea", f_wea, 4'h0);
      adv();
      adv();

      @(negedge clk);
      chk("r_p0_left", 64'(rq0.size()), 64'd0);
      chk("r_p1_left", 64'(rq1.size()), 64'd0);
      chk("f_p0_left", 64'(fq0.size()), 64'd0);
      chk("f_p1_left", 64'(fq1.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: veryl_DMemArbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, SHALL set the byte address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width; byte-enable width is DATA_WIDTH/8.
REQ-003 Parameter RR_EN, default 1, SHALL select round-robin (1) or fixed priority with port 0 highest (0).
REQ-004 i_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 i_pN_valid  in  1  (N=0,1) SHALL flag a request from port N.
REQ-007 o_pN_ready  out  1  SHALL flag that port N's request is accepted this cycle.
REQ-008 i_pN_we  in  1  SHALL select write (1) or read (0).
REQ-009 i_pN_be  in  DATA_WIDTH/8  SHALL carry the byte write enables, ignored on reads.
REQ-010 i_pN_addr  in  ADDRESS_WIDTH  SHALL carry the byte address; unaligned addresses are allowed.
REQ-011 i_pN_wdata  in  DATA_WIDTH  SHALL carry the write data.
REQ-012 o_pN_rvalid  out  1  SHALL pulse for one cycle per completed port N read.
REQ-013 o_pN_rdata  out  DATA_WIDTH  SHALL carry read data, valid while o_pN_rvalid=1.
REQ-014 i_p1_lock  in  1  SHALL request exclusive memory access for port 1 (debug/loader).
REQ-015 o_locked  out  1  SHALL indicate that port 1 holds exclusive access.
REQ-016 o_mea, o_wea, o_adra, o_da  out  1, DATA_WIDTH/8, ADDRESS_WIDTH, DATA_WIDTH  SHALL drive the memory write port.
REQ-017 o_meb, o_adrb  out  1, ADDRESS_WIDTH  SHALL drive the memory read port; i_qb  in  DATA_WIDTH  SHALL return the read data one cycle later.

Function
REQ-018 Accept SHALL occur when i_pN_valid and o_pN_ready are both 1; at most one port SHALL be accepted per cycle.
REQ-019 o_pN_ready SHALL depend combinationally on the valids, the state and the priority pointer, and SHALL NOT depend on o_pN_ready.
REQ-020 An accepted write SHALL drive o_mea=1, o_wea=i_pN_be, o_adra=i_pN_addr and o_da=i_pN_wdata in the same cycle; otherwise o_mea=0 and o_wea=0.
REQ-021 An accepted read SHALL drive o_meb=1 and o_adrb=i_pN_addr in the same cycle; otherwise o_meb=0.
REQ-022 o_pN_rvalid SHALL rise exactly one cycle after read accept, with o_pN_rdata=i_qb; writes SHALL produce no rvalid.
REQ-023 Back-to-back accepts SHALL be sustained at one per cycle, mixing ports, reads and writes freely.
REQ-024 The state machine SHALL have three states: ARB, DRAIN and LOCKED.
REQ-025 In ARB with RR_EN=1, when both ports are valid the grant SHALL go to the port not granted most recently; the pointer SHALL update only on accept.
REQ-026 In ARB with RR_EN=0, when both ports are valid port 0 SHALL always win.
REQ-027 ARB SHALL go to DRAIN when i_p1_lock=1; from the cycle of that transition, port 0 SHALL get no grant.
REQ-028 DRAIN SHALL go to LOCKED once no read response is outstanding, and LOCKED SHALL hold o_locked=1 and grant only port 1.
REQ-029 When i_p1_lock=0, DRAIN or LOCKED SHALL return to ARB on the next cycle, with o_locked=0 in that cycle.
REQ-030 When write and read accept at the same address, read-after-write ordering SHALL follow accept order; write-through is handled by the memory.
REQ-031 o_pN_rdata SHALL hold its last value when o_pN_rvalid=0.

Reset
REQ-032 While i_rst=1, all ready, rvalid and memory-enable outputs SHALL be 0, o_locked SHALL be 0 and o_pN_rdata SHALL be 0.
REQ-033 Reset SHALL set state=ARB and point the priority pointer to port 0.
REQ-034 Reset SHALL discard any outstanding read, so no rvalid is issued in the first cycle after reset even if a read was accepted in the cycle before.

Verification
REQ-035 Port 0 writes 0xDEADBEEF to 0x10 with be=0xF, then reads 0x10 -> the next cycle gives o_p0_rvalid=1, o_p0_rdata=0xDEADBEEF.
REQ-036 Both ports read continuously for 6 cycles with RR_EN=1 -> grants alternate 0,1,0,1,0,1, and each rvalid arrives 1 cycle after its grant on the correct port.
REQ-037 RR_EN=0, both ports valid for 4 cycles -> port 0 is granted all 4 cycles and o_p1_ready stays 0.
REQ-038 Port 0 read accepted, i_p1_lock rises in the same cycle -> DRAIN for 1 cycle, then o_p0_rvalid, o_locked=1 and o_p0_ready=0 until lock drops.
REQ-039 Read accepted, then i_rst=1 the next cycle -> o_p0_rvalid=0 and o_p1_rvalid=0; after reset, the first grant with both ports valid goes to port 0.
